// File: rtl/counter_pkg.sv
// Shared constants for the up/down modulo counter: count direction encoding
// and the saturation limit of the wrap counter.
package counter_pkg;

    localparam logic       MODE_UP      = 1'b0;
    localparam logic       MODE_DOWN    = 1'b1;
    localparam logic [7:0] WRAP_CNT_MAX = 8'd255;

endpackage

// File: rtl/updown_mod_next.sv
// Combinational next-count logic: load clamp, up/down step, wrap detect and
// terminal-count flag for a modulo counter whose range is 0..mod_max.
module updown_mod_next #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] counter,
    input  logic             en,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] mod_max,
    output logic [WIDTH-1:0] count_next,
    output logic             wrap_step,
    output logic             tc
);
    import counter_pkg::*;

    always_comb begin
        count_next = counter;
        wrap_step  = 1'b0;
        tc         = 1'b0;
        if (load) begin
            count_next = (load_val <= mod_max) ? load_val : mod_max;
        end else if (en) begin
            // A count above mod_max (range shrunk mid-count) wraps like a terminal step.
            if (mode == MODE_UP) begin
                if (counter < mod_max) begin
                    count_next = counter + 1'b1;
                end else begin
                    count_next = '0;
                    wrap_step  = 1'b1;
                end
                tc = (counter == mod_max);
            end else begin
                if ((counter == '0) || (counter > mod_max)) begin
                    count_next = mod_max;
                    wrap_step  = 1'b1;
                end else begin
                    count_next = counter - 1'b1;
                end
                tc = (counter == '0);
            end
        end
    end

endmodule

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with clamped synchronous load, terminal-count flag,
// registered wrap pulse and a saturating 8-bit wrap counter.
module updown_mod_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] mod_max,
    output logic [WIDTH-1:0] counter,
    output logic             tc,
    output logic             wrap,
    output logic [7:0]       wrap_cnt
);
    import counter_pkg::*;

    logic [WIDTH-1:0] count_next;
    logic             wrap_step;

    updown_mod_next #(.WIDTH(WIDTH)) u_next (
        .counter    (counter),
        .en         (en),
        .mode       (mode),
        .load       (load),
        .load_val   (load_val),
        .mod_max    (mod_max),
        .count_next (count_next),
        .wrap_step  (wrap_step),
        .tc         (tc)
    );

    // Reset also clears wrap, so a wrap step coinciding with reset never pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            counter  <= '0;
            wrap     <= 1'b0;
            wrap_cnt <= 8'd0;
        end else begin
            counter <= count_next;
            wrap    <= wrap_step;
            if (wrap_step && (wrap_cnt != WRAP_CNT_MAX)) begin
                wrap_cnt <= wrap_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter (WIDTH=4): directed scenarios with literal
// expectations plus an every-cycle comparison against an arithmetic model.
module tb_updown_mod_counter;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic         mode;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] mod_max;
    logic [W-1:0] counter;
    logic         tc;
    logic         wrap;
    logic [7:0]   wrap_cnt;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_v;

    updown_mod_counter #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .mode     (mode),
        .load     (load),
        .load_val (load_val),
        .mod_max  (mod_max),
        .counter  (counter),
        .tc       (tc),
        .wrap     (wrap),
        .wrap_cnt (wrap_cnt)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // ---------------- model ----------------
    int m_cnt  = 0;
    int m_wcnt = 0;
    bit m_wrap = 1'b0;
    bit m_valid = 1'b0;
    int mm;
    int nxt;
    bit w;

    always @(posedge clk) begin
        mm  = int'(mod_max);
        nxt = m_cnt;
        w   = 1'b0;
        if (!reset) begin
            m_cnt  <= 0;
            m_wcnt <= 0;
            m_wrap <= 1'b0;
        end else if (load) begin
            m_cnt  <= (int'(load_val) > mm) ? mm : int'(load_val);
            m_wrap <= 1'b0;
        end else if (en) begin
            if (mode == 1'b0) begin
                w   = (m_cnt >= mm);
                nxt = (m_cnt > mm) ? 0 : (m_cnt + 1) % (mm + 1);
            end else begin
                w   = (m_cnt == 0) || (m_cnt > mm);
                nxt = (m_cnt > mm) ? mm : (m_cnt + mm) % (mm + 1);
            end
            m_cnt  <= nxt;
            m_wrap <= w;
            if (w && m_wcnt < 255) m_wcnt <= m_wcnt + 1;
        end else begin
            m_wrap <= 1'b0;
        end
        m_valid <= 1'b1;
    end

    // ---------------- every-cycle compare ----------------
    always @(negedge clk) begin
        #2;
        if (m_valid) begin
            check("cyc_counter", 32'(counter), 32'(m_cnt));
            check("cyc_wrap", 32'(wrap), 32'(m_wrap));
            check("cyc_wrap_cnt", 32'(wrap_cnt), 32'(m_wcnt));
            check("cyc_tc", 32'(tc),
                  32'(en && !load && (mode ? (m_cnt == 0) : (m_cnt == int'(mod_max)))));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic drive(input logic rst_v, input logic en_v, input logic mode_v,
                         input logic load_v, input logic [W-1:0] lv, input logic [W-1:0] mx);
        reset    = rst_v;
        en       = en_v;
        mode     = mode_v;
        load     = load_v;
        load_val = lv;
        mod_max  = mx;
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd7, 4'd9);
        tick();
        tick();
        check("s1_counter", 32'(counter), 0);
        check("s1_wrap", 32'(wrap), 0);
        check("s1_wrap_cnt", 32'(wrap_cnt), 0);

        // count up 0..9 and wrap
        for (int i = 1; i <= 9; i++) exp_q.push_back(W'(i));
        exp_q.push_back(4'd0);
        exp_q.push_back(4'd1);
        exp_q.push_back(4'd2);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd9);
        for (int i = 0; i < 12; i++) begin
            tick();
            exp_v = exp_q.pop_front();
            check("s2_counter", 32'(counter), 32'(exp_v));
            if (i == 8) check("s2_tc_at_9", 32'(tc), 1);
            if (i == 9) check("s2_wrap_pulse", 32'(wrap), 1);
            if (i == 10) check("s2_wrap_clear", 32'(wrap), 0);
        end
        check("s2_wrap_cnt", 32'(wrap_cnt), 1);

        // count down 1 -> 0 -> 5 -> 4
        drive(1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 4'd5);
        tick();
        check("s3_load", 32'(counter), 1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd5);
        tick();
        check("s3_counter0", 32'(counter), 0);
        check("s3_nowrap", 32'(wrap), 0);
        tick();
        check("s3_counter5", 32'(counter), 5);
        check("s3_wrap", 32'(wrap), 1);
        tick();
        check("s3_counter4", 32'(counter), 4);
        check("s3_wrap_clear", 32'(wrap), 0);
        check("s3_wrap_cnt", 32'(wrap_cnt), 2);

        // clamped load beats enable
        drive(1'b1, 1'b1, 1'b0, 1'b1, 4'd12, 4'd10);
        tick();
        check("s4_clamp", 32'(counter), 10);
        check("s4_nowrap", 32'(wrap), 0);
        check("s4_wrap_cnt", 32'(wrap_cnt), 2);
        check("s4_tc_load", 32'(tc), 0);
        load = 1'b0;
        #1;
        check("s4_tc_en", 32'(tc), 1);
        en = 1'b0;
        tick();
        check("hold_counter", 32'(counter), 10);
        check("hold_wrap", 32'(wrap), 0);

        // range shrunk below current count, up then down
        drive(1'b1, 1'b0, 1'b0, 1'b1, 4'd14, 4'd15);
        tick();
        check("s5_load14", 32'(counter), 14);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd6);
        tick();
        check("s5_counter", 32'(counter), 0);
        check("s5_wrap", 32'(wrap), 1);
        check("s5_wrap_cnt", 32'(wrap_cnt), 3);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 4'd14, 4'd15);
        tick();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd6);
        tick();
        check("dn_oor_counter", 32'(counter), 6);
        check("dn_oor_wrap", 32'(wrap), 1);
        check("dn_oor_wrap_cnt", 32'(wrap_cnt), 4);

        // reset on the same edge as a wrap step
        drive(1'b1, 1'b1, 1'b0, 1'b1, 4'd6, 4'd6);
        tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd6);
        tick();
        check("rst_counter", 32'(counter), 0);
        check("rst_wrap", 32'(wrap), 0);
        check("rst_wrap_cnt", 32'(wrap_cnt), 0);
        reset = 1'b1;
        tick();
        check("post_rst_step", 32'(counter), 1);
        check("post_rst_wrap", 32'(wrap), 0);

        // random mix, checked by the model only
        for (int i = 0; i < 120; i++) begin
            drive(1'($urandom_range(0, 19) != 0), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
                  W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
            tick();
        end

        // mod_max = 0: every step wraps, wrap_cnt saturates
        drive(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 4'd0, 4'd0);
        for (int i = 0; i < 300; i++) begin
            tick();
            check("s6_counter", 32'(counter), 0);
        end
        check("s6_wrap_cnt_sat", 32'(wrap_cnt), 255);
        check("s6_wrap", 32'(wrap), 1);
        reset = 1'b0;
        tick();
        check("s6_rst_wrap_cnt", 32'(wrap_cnt), 0);
        check("s6_rst_wrap", 32'(wrap), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
